rx_link_monitor: RTL and testbench

- Receive-side link supervisor that sequences the descrambler.
- Qualifies the raw PMD signal_status with a stabilization timer before enabling the descrambler.
- Watches the descrambler's locked flag, forces a resync (descrambler held in reset) if lock is not reached in time, and reports link_status to the PCS receive logic.
- Counts lock losses for the management interface.

---
 rtl/rx_link_monitor_pkg.sv | 6 +
 rtl/rx_link_monitor_sat_counter8.sv | 11 +
 rtl/rx_link_monitor.sv | 73 +++++++
 tb/tb_rx_link_monitor.sv | 137 +++++++++++++
 4 files changed

// File: rtl/rx_link_monitor_pkg.sv
// rx_link_monitor_pkg: state encoding and 125 MHz-derived timing defaults for the receive link monitor.
package rx_link_monitor_pkg;
  typedef enum logic [2:0] {DOWN, STABILIZE, WAIT_LOCK, RESYNC, UP} state_t;
  localparam int unsigned STABILIZE_330US = 41250;
  localparam int unsigned STABILIZE_5US = 625;
endpackage

// File: rtl/rx_link_monitor_sat_counter8.sv
// sat_counter8: 8-bit event counter that sticks at 255 instead of wrapping.
module sat_counter8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  output logic [7:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= 8'd0;
    else if (inc && count != 8'hff) count <= count + 8'd1;
endmodule

// File: rtl/rx_link_monitor.sv
// rx_link_monitor: qualifies PMD signal detect, sequences descrambler enable/resync and reports link status.
module rx_link_monitor
  import rx_link_monitor_pkg::*;
#(
  parameter int unsigned STABILIZE_CYCLES = STABILIZE_330US,
  parameter int unsigned TEST_STABILIZE_CYCLES = STABILIZE_5US,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned RESYNC_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       signal_status,
  input  logic       test_mode,
  input  logic       locked,
  output logic       descramble_enable,
  output logic       link_status,
  output logic [7:0] lock_loss_count,
  output logic [7:0] resync_count
);
  localparam logic [15:0] STAB_LOAD = 16'(STABILIZE_CYCLES - 1);
  localparam logic [15:0] TEST_LOAD = 16'(TEST_STABILIZE_CYCLES - 1);
  localparam logic [15:0] LOCK_LOAD = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] RESYNC_LOAD = 16'(RESYNC_CYCLES - 1);
  state_t state, nxt;
  logic [15:0] timer, timer_nxt;
  logic tz, inc_loss, inc_resync;
  assign tz = timer == 16'd0;
  assign inc_loss = state == UP && signal_status && !locked;
  assign inc_resync = state == WAIT_LOCK && signal_status && !locked && tz;
  always_comb begin
    nxt = state;
    timer_nxt = timer;
    case (state)
      DOWN: if (signal_status) begin
        nxt = STABILIZE;
        timer_nxt = test_mode ? TEST_LOAD : STAB_LOAD;
      end
      STABILIZE: begin
        nxt = tz ? WAIT_LOCK : STABILIZE;
        timer_nxt = tz ? LOCK_LOAD : timer - 16'd1;
      end
      WAIT_LOCK: begin
        nxt = locked ? UP : tz ? RESYNC : WAIT_LOCK;
        timer_nxt = tz ? RESYNC_LOAD : timer - 16'd1;
      end
      RESYNC: begin
        nxt = tz ? WAIT_LOCK : RESYNC;
        timer_nxt = tz ? LOCK_LOAD : timer - 16'd1;
      end
      UP: if (!locked) begin
        nxt = WAIT_LOCK;
        timer_nxt = LOCK_LOAD;
      end
      default: nxt = DOWN;
    endcase
    // loss of signal wins over every other condition
    if (!signal_status) nxt = DOWN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= DOWN;
      timer <= 16'd0;
      descramble_enable <= 1'b0;
      link_status <= 1'b0;
    end else begin
      state <= nxt;
      timer <= timer_nxt;
      descramble_enable <= nxt == WAIT_LOCK || nxt == UP;
      link_status <= nxt == UP;
    end
  sat_counter8 u_loss (.clk(clk), .rst_n(rst_n), .inc(inc_loss), .count(lock_loss_count));
  sat_counter8 u_resync (.clk(clk), .rst_n(rst_n), .inc(inc_resync), .count(resync_count));
endmodule

// File: tb/tb_rx_link_monitor.sv
// tb_rx_link_monitor: directed scenarios checked against an elapsed-time link model every cycle.
module tb_rx_link_monitor;
  logic clk = 0, rst_n = 0, signal_status = 0, test_mode = 0, locked = 0;
  logic descramble_enable, link_status;
  logic [7:0] lock_loss_count, resync_count;
  int total = 0, bad = 0;
  rx_link_monitor #(
    .STABILIZE_CYCLES(8), .TEST_STABILIZE_CYCLES(4), .LOCK_TIMEOUT(16), .RESYNC_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .signal_status(signal_status), .test_mode(test_mode),
    .locked(locked), .descramble_enable(descramble_enable), .link_status(link_status),
    .lock_loss_count(lock_loss_count), .resync_count(resync_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // phase: 0 down, 1 stabilizing, 2 waiting for lock, 3 resync, 4 up; age counts cycles spent in phase
  int phase = 0, age = 0, stab_len = 8, m_loss = 0, m_resync = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      phase = 0; age = 0; m_loss = 0; m_resync = 0;
    end else if (!signal_status) phase = 0;
    else if (phase == 0) begin
      phase = 1; age = 0; stab_len = test_mode ? 4 : 8;
    end else if (phase == 1) begin
      age++;
      if (age == stab_len) begin phase = 2; age = 0; end
    end else if (phase == 2) begin
      if (locked) phase = 4;
      else begin
        age++;
        if (age == 16) begin phase = 3; age = 0; m_resync = m_resync < 255 ? m_resync + 1 : 255; end
      end
    end else if (phase == 3) begin
      age++;
      if (age == 2) begin phase = 2; age = 0; end
    end else if (!locked) begin
      phase = 2; age = 0; m_loss = m_loss < 255 ? m_loss + 1 : 255;
    end
  always @(negedge clk) begin
    chk("model_enable", int'(descramble_enable), int'(phase == 2 || phase == 4));
    chk("model_link", int'(link_status), int'(phase == 4));
    chk("model_loss", int'(lock_loss_count), m_loss);
    chk("model_resync", int'(resync_count), m_resync);
  end
  initial begin
    bit found;
    repeat (2) @(negedge clk);
    chk("reset_enable", int'(descramble_enable), 0);
    chk("reset_link", int'(link_status), 0);
    rst_n = 1;
    @(negedge clk);
    signal_status = 1;
    repeat (8) @(negedge clk);
    chk("bringup_enable_early", int'(descramble_enable), 0);
    @(negedge clk);
    chk("bringup_enable_cycle9", int'(descramble_enable), 1);
    repeat (2) @(negedge clk);
    locked = 1;
    @(negedge clk);
    chk("bringup_link", int'(link_status), 1);
    chk("bringup_loss", int'(lock_loss_count), 0);
    chk("bringup_resync", int'(resync_count), 0);
    locked = 0;
    @(negedge clk);
    chk("loss_link", int'(link_status), 0);
    chk("loss_enable", int'(descramble_enable), 1);
    chk("loss_count", int'(lock_loss_count), 1);
    repeat (2) @(negedge clk);
    locked = 1;
    @(negedge clk);
    chk("relock_link", int'(link_status), 1);
    locked = 0; signal_status = 0;
    @(negedge clk);
    chk("simul_enable", int'(descramble_enable), 0);
    chk("simul_loss", int'(lock_loss_count), 1);
    test_mode = 1; signal_status = 1;
    repeat (4) @(negedge clk);
    chk("test_enable_early", int'(descramble_enable), 0);
    @(negedge clk);
    chk("test_enable_cycle5", int'(descramble_enable), 1);
    test_mode = 0; signal_status = 0;
    @(negedge clk);
    signal_status = 1;
    repeat (5) @(negedge clk);
    signal_status = 0;
    @(negedge clk);
    signal_status = 1;
    repeat (8) @(negedge clk);
    chk("abort_enable_early", int'(descramble_enable), 0);
    @(negedge clk);
    chk("abort_enable", int'(descramble_enable), 1);
    chk("abort_loss", int'(lock_loss_count), 1);
    repeat (15) @(negedge clk);
    chk("timeout_enable_held", int'(descramble_enable), 1);
    chk("timeout_resync_before", int'(resync_count), 0);
    @(negedge clk);
    chk("timeout_enable_drop", int'(descramble_enable), 0);
    chk("timeout_resync_1", int'(resync_count), 1);
    @(negedge clk);
    chk("resync_hold", int'(descramble_enable), 0);
    @(negedge clk);
    chk("resync_release", int'(descramble_enable), 1);
    repeat (18) @(negedge clk);
    chk("timeout_resync_2", int'(resync_count), 2);
    repeat (4700) @(negedge clk);
    chk("resync_saturated", int'(resync_count), 255);
    repeat (40) @(negedge clk);
    chk("resync_stays_255", int'(resync_count), 255);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      found = !descramble_enable;
    end
    chk("find_resync", int'(found), 1);
    #2 rst_n = 0;
    #1;
    chk("async_enable", int'(descramble_enable), 0);
    chk("async_link", int'(link_status), 0);
    chk("async_loss", int'(lock_loss_count), 0);
    chk("async_resync", int'(resync_count), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (8) @(negedge clk);
    chk("post_reset_early", int'(descramble_enable), 0);
    @(negedge clk);
    chk("post_reset_enable", int'(descramble_enable), 1);
    chk("post_reset_resync", int'(resync_count), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
